// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding and
// master index constants.
package bus_arbiter_2m_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating hold counter: counts the cycles an owner keeps the bus while the
// other master waits; tc flags the last cycle before preemption.
module arb_hold_cnt #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TC_VAL  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // MAX_HOLD of zero turns preemption off entirely.
   assign tc = (MAX_HOLD != 0) && (cnt == TC_VAL);

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master bus arbiter: round-robin on ties from idle, direct handoff when
// the owner drops its request, and bounded hold time while the other waits.
module bus_arbiter_2m
   import bus_arbiter_2m_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       m0_req,
   input  logic       m1_req,
   output logic       m0_grant,
   output logic       m1_grant,
   output logic       m_sel,
   output logic       busy,
   output logic       preempt,
   output arb_state_t state_dbg
);

   arb_state_t state, state_next;
   logic       last_q;
   logic       m_sel_q;
   logic       preempt_q, preempt_next;
   logic       other_req;
   logic       hold_clr, hold_tc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         last_q    <= M1;
         m_sel_q   <= M0;
         preempt_q <= 1'b0;
      end else begin
         state     <= state_next;
         preempt_q <= preempt_next;
         // In IDLE both last_q and m_sel_q hold, so the mux never glitches.
         if (state_next == GNT0) begin
            last_q  <= M0;
            m_sel_q <= M0;
         end else if (state_next == GNT1) begin
            last_q  <= M1;
            m_sel_q <= M1;
         end
      end
   end

   always_comb begin
      state_next   = state;
      preempt_next = 1'b0;
      other_req    = 1'b0;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_next = (last_q == M0) ? GNT1 : GNT0;
            end else if (m0_req) begin
               state_next = GNT0;
            end else if (m1_req) begin
               state_next = GNT1;
            end
         end
         GNT0: begin
            other_req = m1_req;
            if (!m0_req) begin
               state_next = m1_req ? GNT1 : IDLE;
            end else if (m1_req && hold_tc) begin
               state_next   = GNT1;
               preempt_next = 1'b1;
            end
         end
         GNT1: begin
            other_req = m0_req;
            if (!m1_req) begin
               state_next = m0_req ? GNT0 : IDLE;
            end else if (m0_req && hold_tc) begin
               state_next   = GNT0;
               preempt_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign hold_clr = (state_next != state) || !other_req;

   arb_hold_cnt #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) u_hold_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (hold_clr),
      .en      (other_req),
      .tc      (hold_tc)
   );

   assign m0_grant  = (state == GNT0);
   assign m1_grant  = (state == GNT1);
   assign busy      = (state != IDLE);
   assign m_sel     = m_sel_q;
   assign preempt   = preempt_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Bench for bus_arbiter_2m: directed scenarios plus random requests, checked
// against an ownership-level reference model.
module tb_bus_arbiter_2m;
   import bus_arbiter_2m_pkg::*;

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 8;
   localparam int SAT      = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       m0_req = 1'b0;
   logic       m1_req = 1'b0;
   logic       m0_grant, m1_grant, m_sel, busy, preempt;
   arb_state_t state_dbg;

   int checks = 0;
   int errors = 0;

   logic [4:0] exp_q[$];

   // reference model: owner index (-1 = nobody), round-robin memory, wait count
   int   own;
   logic last_m;
   int   waited;
   logic sel_m;
   logic pre_m;

   bus_arbiter_2m #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m0_req    (m0_req),
      .m1_req    (m1_req),
      .m0_grant  (m0_grant),
      .m1_grant  (m1_grant),
      .m_sel     (m_sel),
      .busy      (busy),
      .preempt   (preempt),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   function logic [4:0] pack_obs();
      return {m0_grant, m1_grant, m_sel, busy, preempt};
   endfunction

   task model_reset();
      own    = -1;
      last_m = 1'b1;
      waited = 0;
      sel_m  = 1'b0;
      pre_m  = 1'b0;
      exp_q.delete();
   endtask

   task model_step(input logic r0, input logic r1);
      int   nxt;
      logic mine;
      logic oth;
      nxt   = own;
      pre_m = 1'b0;
      oth   = 1'b0;
      if (own < 0) begin
         if (r0 && r1) nxt = (last_m == 1'b1) ? 0 : 1;
         else if (r0)  nxt = 0;
         else if (r1)  nxt = 1;
      end else begin
         mine = (own == 0) ? r0 : r1;
         oth  = (own == 0) ? r1 : r0;
         if (!mine) begin
            nxt = oth ? 1 - own : -1;
         end else if (oth && MAX_HOLD != 0 && waited == MAX_HOLD - 1) begin
            nxt   = 1 - own;
            pre_m = 1'b1;
         end
      end
      if (own < 0 || nxt != own || !oth) waited = 0;
      else if (waited < SAT) waited++;
      if (nxt >= 0) begin
         last_m = nxt[0];
         sel_m  = nxt[0];
      end
      own = nxt;
      exp_q.push_back({own == 0, own == 1, sel_m, own >= 0, pre_m});
   endtask

   task step(input logic r0, input logic r1);
      @(negedge clk);
      m0_req = r0;
      m1_req = r1;
      @(posedge clk);
      model_step(r0, r1);
      #1;
   endtask

   task apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      m0_req  = 1'b0;
      m1_req  = 1'b0;
      repeat (3) @(posedge clk);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task test_reset();
      logic [4:0] exp;
      @(negedge clk);
      reset_n = 1'b0;
      m0_req  = 1'b0;
      m1_req  = 1'b0;
      #1;
      checks++;
      if (pack_obs() !== 5'b00000 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset_outputs: got %b state %b, expected 00000 state 00", pack_obs(), state_dbg);
      end
      repeat (3) @(posedge clk);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         exp = exp_q.pop_front();
         checks++;
         if (pack_obs() !== exp || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got %b state %b, expected %b state 00", i, pack_obs(), state_dbg, exp);
         end
      end
   endtask

   task test_single_master();
      logic [4:0] exp;
      apply_reset();
      repeat (4) step(1'b0, 1'b0);
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1);
         exp = exp_q.pop_front();
         checks++;
         if (pack_obs() !== exp || {m1_grant, m_sel, busy} !== 3'b111) begin
            errors++;
            $display("FAIL single_grant[%0d]: got %b, expected %b", i, pack_obs(), exp);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0);
         exp = exp_q.pop_front();
         checks++;
         if (pack_obs() !== exp || {m1_grant, m_sel, busy} !== 3'b010) begin
            errors++;
            $display("FAIL single_release[%0d]: got %b, expected %b", i, pack_obs(), exp);
         end
      end
   endtask

   task test_tie();
      logic [4:0] exp;
      apply_reset();
      step(1'b1, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (pack_obs() !== exp || {m0_grant, m1_grant} !== 2'b10) begin
         errors++;
         $display("FAIL tie_first: got %b, expected %b", pack_obs(), exp);
      end
      step(1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (pack_obs() !== exp) begin
         errors++;
         $display("FAIL tie_idle: got %b, expected %b", pack_obs(), exp);
      end
      step(1'b1, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (pack_obs() !== exp || {m0_grant, m1_grant} !== 2'b01) begin
         errors++;
         $display("FAIL tie_second: got %b, expected %b", pack_obs(), exp);
      end
      step(1'b0, 1'b0);
      exp_q.delete();
   endtask

   task test_handoff();
      logic [4:0] exp;
      apply_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      exp_q.delete();
      step(1'b0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (pack_obs() !== exp || {m0_grant, m1_grant, busy, preempt} !== 4'b0110) begin
         errors++;
         $display("FAIL handoff: got %b, expected %b", pack_obs(), exp);
      end
      step(1'b0, 1'b0);
      exp_q.delete();
   endtask

   task test_preempt();
      logic [4:0] exp;
      int         owner_exp;
      logic       pre_exp;
      int         pulses;
      pulses = 0;
      apply_reset();
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 1'b1);
         owner_exp = (k / MAX_HOLD) % 2;
         pre_exp   = (k > 0) && (k % MAX_HOLD == 0);
         if (preempt === 1'b1) pulses++;
         exp = exp_q.pop_front();
         checks++;
         if (pack_obs() !== exp ||
             {m0_grant, m1_grant, preempt} !== {owner_exp == 0, owner_exp == 1, pre_exp}) begin
            errors++;
            $display("FAIL preempt[%0d]: got %b, expected %b (owner %0d preempt %b)", k, pack_obs(), exp, owner_exp, pre_exp);
         end
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL preempt_pulses: got %0d, expected 4", pulses);
      end
      step(1'b0, 1'b0);
      exp_q.delete();
   endtask

   task test_async_reset();
      logic [4:0] exp;
      apply_reset();
      step(1'b0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (pack_obs() !== exp || m1_grant !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got %b, expected %b", pack_obs(), exp);
      end
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({m0_grant, m1_grant, busy, preempt} !== 4'b0000) begin
         errors++;
         $display("FAIL async_drop: got %b, expected 0000", {m0_grant, m1_grant, busy, preempt});
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b1, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (pack_obs() !== exp || {m0_grant, m1_grant} !== 2'b10) begin
         errors++;
         $display("FAIL async_restart: got %b, expected %b", pack_obs(), exp);
      end
      step(1'b0, 1'b0);
      exp_q.delete();
   endtask

   task test_random();
      logic [4:0] exp;
      logic       r0, r1;
      r0 = 1'b0;
      r1 = 1'b0;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3, 0) == 0) r0 = ~r0;
         if ($urandom_range(3, 0) == 0) r1 = ~r1;
         step(r0, r1);
         exp = exp_q.pop_front();
         checks++;
         if (pack_obs() !== exp || (m0_grant === 1'b1 && m1_grant === 1'b1)) begin
            errors++;
            $display("FAIL random[%0d]: req %b%b got %b, expected %b", i, r0, r1, pack_obs(), exp);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_master();
      test_tie();
      test_handoff();
      test_preempt();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master bus arbiter FSM that shares the single slave-side bus between master 0 and master 1.
- Outputs drive the bus grant lines and the select of the master-side address/write/data muxes in front of the slave decoder.
- Fairness:
  - Round-robin on simultaneous requests from idle.
  - Bounded hold time: a master owning the bus is preempted after MAX_HOLD cycles if the other master is waiting.

Parameters:
- MAX_HOLD, 16: max consecutive cycles an owner keeps the grant while the other master requests. 0 disables preemption. Legal range 0..255.
- CNT_W, 8: hold counter width. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- m0_req  input  1  master 0 bus request, level, held while a transfer is wanted.
- m1_req  input  1  master 1 bus request, level.
- m0_grant  output  1  master 0 owns the bus (registered).
- m1_grant  output  1  master 1 owns the bus (registered).
- m_sel  output  1  datapath mux select: 0 = master 0 path, 1 = master 1 path (registered).
- busy  output  1  some master owns the bus.
- preempt  output  1  one-cycle pulse on the cycle the grant moves because of the hold limit.

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low.
- On reset:
  - state = IDLE.
  - m0_grant = 0, m1_grant = 0, m_sel = 0, busy = 0, preempt = 0.
  - hold_cnt = 0, last = 1, so master 0 wins the first tie.
- States: IDLE, GNT0, GNT1. All outputs are Moore, decoded from registered state/flags. Grant latency is one edge: a req sampled at edge t gives a grant visible after edge t.
- m0_grant = (state==GNT0). m1_grant = (state==GNT1). busy = (state!=IDLE).
- m_sel = 1 in GNT1. m_sel = 0 in GNT0. In IDLE, m_sel keeps its last value, so the mux does not glitch on idle.
- IDLE transitions:
  - m0_req only -> GNT0.
  - m1_req only -> GNT1.
  - both -> master != last (round robin).
  - none -> stay.
- GNT0 transitions (GNT1 is symmetric):
  - m0_req=0 and m1_req=1 -> GNT1 directly (no dead cycle).
  - m0_req=0 and m1_req=0 -> IDLE.
  - m0_req=1, m1_req=1 and hold_cnt == MAX_HOLD-1 (MAX_HOLD != 0) -> GNT1, with preempt=1 for one cycle.
  - otherwise stay.
- last is updated to the granted master on every entry to GNT0/GNT1.
- Hold counter:
  - Clears to 0 on every state change.
  - Clears to 0 while the non-owner is not requesting.
  - Increments each cycle in GNTx while the other master requests.
  - Saturates, never wraps.
- Preempted master: keeps its req high and is re-granted under the same rules. With both masters requesting continuously, ownership alternates every MAX_HOLD cycles.
- Never both grants high; one-hot-or-zero in every cycle.
- Reset mid-grant: all grants drop immediately (asynchronous). After release, the arbiter restarts from IDLE with last=1.
- Requests that toggle within a cycle are not seen; only the edge-sampled value counts.

Decomposition:
- Shared bus package holds:
  - state encoding constants IDLE=2'b00, GNT0=2'b01, GNT1=2'b10;
  - master index constants M0=1'b0, M1=1'b1.
- One natural sub-module: arb_hold_cnt (saturating up-counter with clear/enable, CNT_W wide, terminal-count compare to MAX_HOLD-1).
- FSM next-state and output logic stay in bus_arbiter_2m.

Test Plan:
- Reset then idle: reset_n low 3 cycles, no requests -> all outputs 0, state IDLE for 10 cycles.
- Single master: m1_req=1 at cycle 5, dropped at cycle 9 -> m1_grant=1, m_sel=1, busy=1 on cycles 6..9; 0 from cycle 10; m_sel stays 1.
- Tie from idle: m0_req=m1_req=1 first after reset -> m0_grant next cycle. Repeat the tie after returning to IDLE -> m1_grant, since last alternates.
- Handoff: GNT0 with m1_req=1, drop m0_req at edge t -> m1_grant=1 after edge t, no IDLE cycle, preempt=0.
- Preemption: MAX_HOLD=4, both requests held high from an M0 grant -> m0_grant 4 cycles, then m1_grant 4 cycles, repeating. preempt pulses exactly once at each switch. Never both grants 1.
- Async reset mid-grant: reset_n low between clock edges while m1_grant=1 -> m1_grant=0 before the next edge. After release with both requests high -> m0_grant first.
